// File: rtl/lw_hmac_feeder.sv
// lw_hmac_feeder: drives the HMAC/SHA engine request port from a raw host
// byte stream, generating SHA-2 padding and feeding the HMAC key on demand.
module lw_hmac_feeder #(
    parameter int LEN_W = 32
) (
    input  logic              clk_i,
    input  logic              aresetn_i,
    input  logic              req_i,
    input  logic [1:0]        op_i,
    input  logic [511:0]      key_i,
    input  logic [31:0]       in_data_i,
    input  logic              in_valid_i,
    input  logic              in_last_i,
    input  logic [2:0]        in_bytes_i,
    output logic              in_ready_o,
    input  logic              abort_i,
    output logic              start_o,
    output logic [1:0]        opcode_o,
    output logic [31:0]       data_o,
    output logic              data_valid_o,
    output logic              last_o,
    output logic [31:0]       key_o,
    output logic              key_valid_o,
    input  logic              core_ready_i,
    input  logic              ready_i,
    input  logic              key_ready_i,
    input  logic              done_i,
    input  logic [7:0][31:0]  hash_i,
    output logic              abort_o,
    output logic              busy_o,
    output logic [7:0][31:0]  digest_o,
    output logic              digest_valid_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_KEY,
        S_MSG,
        S_PAD,
        S_LEN,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    logic [1:0]        op_q;
    logic [15:0][31:0] key_q;
    logic [LEN_W-1:0]  cnt;
    logic [3:0]        wi;
    logic [3:0]        kc;
    // marker word still owed (last host word was full)
    logic              pend;
    // padding must first run past wi 15 into a fresh block
    logic              wrap;

    logic              full_last;
    logic [2:0]        nbytes;
    logic [LEN_W:0]    sum;
    logic [LEN_W-1:0]  cnt_next;
    logic [63:0]       tot;
    logic [63:0]       bitlen;
    logic [31:0]       msg_word;

    assign full_last = in_bytes_i >= 3'd4;
    assign nbytes    = (in_last_i && !full_last) ? in_bytes_i : 3'd4;
    assign sum       = {1'b0, cnt} + (LEN_W+1)'(nbytes);
    assign cnt_next  = sum[LEN_W] ? '1 : sum[LEN_W-1:0];
    assign tot       = 64'(cnt) + (op_q[1] ? 64'd64 : 64'd0);
    assign bitlen    = tot << 3;

    assign abort_o        = abort_i;
    assign busy_o         = state != S_IDLE;
    assign opcode_o       = busy_o ? op_q : 2'b00;
    assign digest_valid_o = state == S_DONE;

    // Trim the final host word and insert the 0x80 marker after its last byte
    always_comb begin
        msg_word = in_data_i;
        if (in_last_i && !full_last) begin
            unique case (in_bytes_i)
                3'd1:    msg_word = {in_data_i[31:24], 24'h80_0000};
                3'd2:    msg_word = {in_data_i[31:16], 16'h8000};
                3'd3:    msg_word = {in_data_i[31:8], 8'h80};
                default: msg_word = 32'h8000_0000;
            endcase
        end
    end

    // Engine-side and host-side handshake outputs decoded from the state
    always_comb begin
        start_o      = 1'b0;
        data_o       = '0;
        data_valid_o = 1'b0;
        last_o       = 1'b0;
        key_o        = '0;
        key_valid_o  = 1'b0;
        in_ready_o   = 1'b0;
        unique case (state)
            S_START: begin
                start_o      = 1'b1;
                data_valid_o = 1'b1;
            end
            S_KEY: begin
                key_valid_o = 1'b1;
                key_o       = key_q[kc];
            end
            S_MSG: begin
                in_ready_o   = ready_i;
                data_valid_o = in_valid_i;
                data_o       = msg_word;
            end
            S_PAD: begin
                data_valid_o = 1'b1;
                data_o       = pend ? 32'h8000_0000 : 32'h0;
            end
            S_LEN: begin
                data_valid_o = 1'b1;
                last_o       = wi == 4'd15;
                data_o       = (wi == 4'd15) ? bitlen[31:0]
                                             : bitlen[63:32];
            end
            default: ;
        endcase
    end

    // Sequencer: request capture, key feed, message, padding, length, digest
    always_ff @(posedge clk_i) begin
        if (!aresetn_i) begin
            state    <= S_IDLE;
            op_q     <= '0;
            key_q    <= '0;
            cnt      <= '0;
            wi       <= '0;
            kc       <= '0;
            pend     <= 1'b0;
            wrap     <= 1'b0;
            digest_o <= '0;
        end else if (abort_i && state != S_IDLE) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_i && core_ready_i) begin
                        op_q  <= op_i;
                        key_q <= key_i;
                        cnt   <= '0;
                        wi    <= '0;
                        kc    <= 4'd15;
                        pend  <= 1'b0;
                        wrap  <= 1'b0;
                        state <= S_START;
                    end
                end
                S_START: state <= op_q[1] ? S_KEY : S_MSG;
                S_KEY: begin
                    if (key_ready_i) begin
                        kc <= kc - 4'd1;
                        if (kc == 4'd0) state <= S_MSG;
                    end
                end
                S_MSG: begin
                    if (in_valid_i && ready_i) begin
                        wi  <= wi + 4'd1;
                        cnt <= cnt_next;
                        if (in_last_i) begin
                            if (full_last) begin
                                pend  <= 1'b1;
                                state <= S_PAD;
                            end else if (wi == 4'd13) begin
                                state <= S_LEN;
                            end else begin
                                wrap  <= wi == 4'd14;
                                state <= S_PAD;
                            end
                        end
                    end
                end
                S_PAD: begin
                    if (ready_i) begin
                        wi   <= wi + 4'd1;
                        pend <= 1'b0;
                        if (pend && wi == 4'd14) wrap <= 1'b1;
                        else if (wi == 4'd15) wrap <= 1'b0;
                        if (wi == 4'd13 && !wrap) state <= S_LEN;
                    end
                end
                S_LEN: begin
                    if (ready_i) begin
                        wi <= wi + 4'd1;
                        if (wi == 4'd15) state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (done_i) begin
                        digest_o <= hash_i;
                        if (op_q[0]) digest_o[0] <= '0;
                        state <= S_DONE;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lw_hmac_feeder.sv
// tb_lw_hmac_feeder: scoreboard bench; expected engine traffic is derived
// from SHA-2 padding rules applied to a byte queue, checked by a monitor.
module tb_lw_hmac_feeder;

    typedef byte unsigned bq_t[$];

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic              aresetn_i, req_i, in_valid_i, in_last_i, in_ready_o;
    logic [1:0]        op_i, opcode_o;
    logic [511:0]      key_i;
    logic [31:0]       in_data_i, data_o, key_o;
    logic [2:0]        in_bytes_i;
    logic              abort_i, start_o, data_valid_o, last_o, key_valid_o;
    logic              core_ready_i, ready_i, key_ready_i, done_i;
    logic              abort_o, busy_o, digest_valid_o;
    logic [7:0][31:0]  hash_i, digest_o;

    lw_hmac_feeder #(.LEN_W(32)) dut (
        .clk_i(clk_i), .aresetn_i(aresetn_i), .req_i(req_i), .op_i(op_i),
        .key_i(key_i), .in_data_i(in_data_i), .in_valid_i(in_valid_i),
        .in_last_i(in_last_i), .in_bytes_i(in_bytes_i),
        .in_ready_o(in_ready_o), .abort_i(abort_i), .start_o(start_o),
        .opcode_o(opcode_o), .data_o(data_o), .data_valid_o(data_valid_o),
        .last_o(last_o), .key_o(key_o), .key_valid_o(key_valid_o),
        .core_ready_i(core_ready_i), .ready_i(ready_i),
        .key_ready_i(key_ready_i), .done_i(done_i), .hash_i(hash_i),
        .abort_o(abort_o), .busy_o(busy_o), .digest_o(digest_o),
        .digest_valid_o(digest_valid_o)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [1:0]   exp_start[$];
    logic [31:0]  exp_key[$];
    logic [32:0]  exp_data[$];
    logic [255:0] exp_dig[$];
    logic [255:0] last_dig = '0;
    logic [1:0]   cur_op = 2'b00;
    bit auto_rdy = 1'b1;
    bit auto_done = 1'b1;
    bit stall = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Engine backpressure, randomized when stalls are enabled
    initial forever begin
        @(posedge clk_i);
        #1;
        if (auto_rdy) begin
            ready_i     = !stall || ($urandom_range(0, 2) != 0);
            key_ready_i = !stall || ($urandom_range(0, 2) != 0);
        end
    end

    // Engine digest: some cycles after the final word, return a random hash
    initial begin
        logic [255:0] e;
        forever begin
            @(negedge clk_i);
            if (auto_done && aresetn_i && data_valid_o && ready_i &&
                last_o && !start_o) begin
                repeat ($urandom_range(1, 4)) @(posedge clk_i);
                #1;
                for (int i = 0; i < 8; i++) hash_i[i] = $urandom;
                e = hash_i;
                if (cur_op[0]) e[31:0] = '0;
                exp_dig.push_back(e);
                done_i = 1'b1;
                @(posedge clk_i);
                #1;
                done_i = 1'b0;
            end
        end
    end

    // Monitor: pop and compare whenever the DUT completes a transfer
    always @(negedge clk_i) begin
        if (aresetn_i) begin
            if (start_o) begin
                if (exp_start.size() == 0) chk("start_unexpected", exp_start.size(), 1);
                else chk("start_op_data", {data_o, opcode_o},
                         {32'h0, exp_start.pop_front()});
            end else if (data_valid_o && ready_i) begin
                if (exp_data.size() == 0) chk("data_unexpected", exp_data.size(), 1);
                else chk("data_word", {last_o, data_o}, exp_data.pop_front());
            end
            if (key_valid_o && key_ready_i) begin
                if (exp_key.size() == 0) chk("key_unexpected", exp_key.size(), 1);
                else chk("key_word", key_o, exp_key.pop_front());
            end
            if (digest_valid_o) begin
                if (exp_dig.size() == 0) chk("digest_unexpected", exp_dig.size(), 1);
                else begin
                    last_dig = exp_dig.pop_front();
                    chk("digest", digest_o, last_dig);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [511:0] key);
        exp_start.push_back(op);
        if (op[1])
            for (int i = 15; i >= 0; i--) exp_key.push_back(key[32*i +: 32]);
        cur_op = op;
        op_i   = op;
        key_i  = key;
        req_i  = 1'b1;
        step();
        req_i = 1'b0;
        op_i  = 2'($urandom);
        key_i = {16{$urandom}};
    endtask

    task automatic send_word(input logic [31:0] d, input logic last,
                             input logic [2:0] nb);
        int t = 0;
        if (stall && $urandom_range(0, 3) == 0) begin
            in_valid_i = 1'b0;
            repeat ($urandom_range(1, 2)) step();
        end
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_last_i  = last;
        in_bytes_i = nb;
        forever begin
            @(negedge clk_i);
            if (in_ready_o || t > 3000) break;
            t++;
        end
        if (t > 3000) chk("host_word_accept", in_ready_o, 1);
        step();
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        in_data_i  = $urandom;
    endtask

    // Reference: SHA-2 padding of the byte message, then host word stream
    task automatic feed(input bq_t m, input bit hmac);
        bq_t p;
        longint unsigned bits;
        int n, nw, nb;
        logic [31:0] d;
        logic l;
        n = m.size();
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = (64'(n) + (hmac ? 64'd64 : 64'd0)) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        for (int i = 0; i < p.size(); i += 4) begin
            l = (i + 4 == p.size());
            exp_data.push_back({l, p[i], p[i+1], p[i+2], p[i+3]});
        end
        nw = (n == 0) ? 1 : (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            d = $urandom;
            for (int b = 0; b < 4; b++)
                if (4*w + b < n) d[8*(3-b) +: 8] = m[4*w + b];
            l  = (w == nw - 1);
            nb = l ? n - 4*w : 4;
            send_word(d, l, 3'(nb));
        end
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        @(negedge clk_i);
        while (busy_o && t < 3000) begin
            @(negedge clk_i);
            t++;
        end
        chk({nm, "_idle"}, busy_o, 0);
        chk({nm, "_data_left"}, exp_data.size(), 0);
        chk({nm, "_digest_left"}, exp_dig.size(), 0);
        step();
    endtask

    task automatic run_op(input string nm, input logic [1:0] op,
                          input logic [511:0] key, input bq_t m);
        issue(op, key);
        feed(m, op[1]);
        wait_idle(nm);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bq_t m;
        logic [511:0] k;
        int lens[$] = '{55, 56, 57, 59, 60, 63, 64, 119, 120};
        int t;
        aresetn_i = 0; req_i = 0; op_i = 0; key_i = '0; in_data_i = 0;
        in_valid_i = 0; in_last_i = 0; in_bytes_i = 0; abort_i = 0;
        core_ready_i = 1; ready_i = 1; key_ready_i = 1; done_i = 0;
        hash_i = '0;
        repeat (3) step();
        @(negedge clk_i);
        chk("reset_outputs", {start_o, opcode_o, data_o, data_valid_o,
            last_o, key_o, key_valid_o, in_ready_o, busy_o,
            digest_valid_o, abort_o}, 0);
        chk("reset_digest", digest_o, 0);
        step();
        aresetn_i = 1;

        core_ready_i = 0;
        op_i = 2'b10;
        req_i = 1;
        step();
        req_i = 0;
        core_ready_i = 1;
        abort_i = 1;
        @(negedge clk_i);
        chk("req_not_ready_ignored", busy_o, 0);
        chk("idle_abort_fwd", {abort_o, busy_o}, 2'b10);
        step();
        abort_i = 0;

        run_op("sha256_abc", 2'b00, '0, s2q("abc"));
        k = {32'h4a656665, 480'h0};
        run_op("hmac_jefe", 2'b10, k,
               s2q("what do ya want for nothing?"));
        m.delete();
        for (int i = 0; i < 56; i++) m.push_back(8'($urandom));
        run_op("sha256_56", 2'b00, '0, m);
        m.delete();
        run_op("sha224_empty", 2'b01, '0, m);
        run_op("sha256_empty", 2'b00, '0, m);
        stall = 1;
        run_op("hmac_abc_stall", 2'b10, k, s2q("abc"));
        stall = 0;

        auto_rdy = 0;
        step();
        ready_i = 1;
        key_ready_i = 0;
        for (int i = 0; i < 16; i++) k[32*i +: 32] = $urandom;
        issue(2'b10, k);
        key_ready_i = 1;
        repeat (9) step();
        key_ready_i = 0;
        abort_i = 1;
        @(negedge clk_i);
        chk("abort_fwd", abort_o, 1);
        chk("abort_at_key7", key_o, k[7*32 +: 32]);
        chk("abort_keys_left", exp_key.size(), 8);
        step();
        abort_i = 0;
        @(negedge clk_i);
        chk("abort_quiet", {busy_o, key_valid_o, in_ready_o,
            digest_valid_o}, 0);
        exp_key.delete();
        step();
        key_ready_i = 1;
        auto_rdy = 1;
        run_op("after_abort", 2'b00, k, s2q("abc"));

        auto_rdy = 0;
        step();
        ready_i = 1;
        key_ready_i = 1;
        issue(2'b00, k);
        feed(s2q("abc"), 0);
        ready_i = 0;
        aresetn_i = 0;
        step();
        @(negedge clk_i);
        chk("pad_reset_outputs", {start_o, opcode_o, data_o, data_valid_o,
            last_o, key_o, key_valid_o, in_ready_o, busy_o,
            digest_valid_o}, 0);
        chk("pad_reset_digest", digest_o, 0);
        chk("pad_reset_words_left", exp_data.size(), 15);
        step();
        aresetn_i = 1;
        exp_data.delete();
        ready_i = 1;
        auto_rdy = 1;
        run_op("after_reset", 2'b00, k, s2q("abc"));

        auto_done = 0;
        issue(2'b00, k);
        feed(s2q("abc"), 0);
        t = 0;
        while (exp_data.size() != 0 && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        chk("collide_drain", exp_data.size(), 0);
        step();
        step();
        for (int i = 0; i < 8; i++) hash_i[i] = $urandom;
        abort_i = 1;
        done_i = 1;
        @(negedge clk_i);
        chk("collide_abort_fwd", abort_o, 1);
        step();
        abort_i = 0;
        done_i = 0;
        repeat (3) @(negedge clk_i);
        chk("collide_idle", busy_o, 0);
        chk("collide_digest_held", digest_o, last_dig);
        step();
        auto_done = 1;

        for (int r = 0; r < 18; r++) begin
            int len;
            logic [1:0] op;
            len = (r < lens.size()) ? lens[r] : $urandom_range(0, 130);
            op = 2'($urandom);
            stall = $urandom_range(0, 1);
            for (int i = 0; i < 16; i++) k[32*i +: 32] = $urandom;
            m.delete();
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
            run_op($sformatf("rand%0d_len%0d_op%0d", r, len, op), op, k, m);
        end

        chk("queues_empty", exp_start.size() + exp_key.size() +
            exp_data.size() + exp_dig.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
